// File: rtl/pixel_reorder_combinator.sv
// pixel_reorder_combinator: walks the frame in raster order, pops matching queue heads and streams pixels in order
// Ports:
//   clk, reset (async, active-low)
//   start                      : begin a frame at (0,0); only honoured in IDLE or DONE
//   q_en_i/q_colour_i/q_xpixel_i/q_ypixel_i : packed per-queue head valid, colour and coordinates
//   xpixel_check/ypixel_check  : expected coordinate broadcast to every queue
//   q_pop_o                    : one-hot pop of the matched queue head
//   pix_colour_o/pix_valid_o/pix_ready_i/pix_sof_o/pix_eol_o : in-order pixel stream
//   busy, frame_done, lost_err : status; lost_err is sticky until reset or start
module pixel_reorder_combinator #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE = 24,
  parameter int NUM_QUEUES = 4,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [RBG_SIZE-1:0] FILL_COLOUR = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_QUEUES-1:0]            q_en_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0]   q_colour_i,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_xpixel_i,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_ypixel_i,
  output logic [DATA_WIDTH-1:0]            xpixel_check,
  output logic [DATA_WIDTH-1:0]            ypixel_check,
  output logic [NUM_QUEUES-1:0]            q_pop_o,
  output logic [RBG_SIZE-1:0]              pix_colour_o,
  output logic                             pix_valid_o,
  input  logic                             pix_ready_i,
  output logic                             pix_sof_o,
  output logic                             pix_eol_o,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             lost_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, EMIT, DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [NUM_QUEUES-1:0] w_match, w_pop;
  logic [RBG_SIZE-1:0]   w_colour;
  logic                  w_hit, w_timeout, w_start, w_accept, w_last, w_load;

  genvar g;
  generate
    for (g = 0; g < NUM_QUEUES; g++) begin : g_match
      assign w_match[g] = q_en_i[g] &&
                          q_xpixel_i[g*DATA_WIDTH +: DATA_WIDTH] == xpixel_check &&
                          q_ypixel_i[g*DATA_WIDTH +: DATA_WIDTH] == ypixel_check;
    end
  endgenerate

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_pop = '0;
    w_colour = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_pop = '0;
        w_pop[i] = 1'b1;
        w_colour = q_colour_i[i*RBG_SIZE +: RBG_SIZE];
      end
    end
  end

  assign w_hit = |w_match;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_accept = r_state == EMIT && pix_ready_i;
  assign w_last = xpixel_check == X_LAST && ypixel_check == Y_LAST;
  assign w_timeout = r_state == SEARCH && !w_hit && r_cnt == T_LAST;
  assign w_load = r_state == SEARCH && (w_hit || w_timeout);

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = w_start ? SEARCH :
             w_load ? EMIT :
             w_accept ? (w_last ? DONE : SEARCH) : r_state;
  end

  always_comb begin
    q_pop_o = r_state == SEARCH ? w_pop : '0;
    pix_valid_o = r_state == EMIT;
    busy = r_state == SEARCH || r_state == EMIT;
    frame_done = w_accept && w_last;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      xpixel_check <= '0;
      ypixel_check <= '0;
      r_cnt <= '0;
      lost_err <= 1'b0;
      pix_colour_o <= '0;
      pix_sof_o <= 1'b0;
      pix_eol_o <= 1'b0;
    end else begin
      if (w_start) begin
        xpixel_check <= '0;
        ypixel_check <= '0;
        r_cnt <= '0;
        lost_err <= 1'b0;
      end else if (w_accept && !w_last) begin
        xpixel_check <= xpixel_check == X_LAST ? '0 : xpixel_check + 1'b1;
        ypixel_check <= xpixel_check == X_LAST ? ypixel_check + 1'b1 : ypixel_check;
        r_cnt <= '0;
      end else if (r_state == SEARCH && !w_load) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) lost_err <= 1'b1;
      // sof/eol are captured with the colour so they stay put during backpressure
      if (w_load) begin
        pix_colour_o <= w_hit ? w_colour : FILL_COLOUR;
        pix_sof_o <= xpixel_check == '0 && ypixel_check == '0;
        pix_eol_o <= xpixel_check == X_LAST;
      end
    end
endmodule

// File: tb/tb_pixel_reorder_combinator.sv
// tb_pixel_reorder_combinator: randomized queue contents checked against a raster-order reference model
module tb_pixel_reorder_combinator;
  localparam int NQ = 4;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int NP = XS * YS;
  localparam int TO = 8;
  localparam logic [23:0] FILL = 24'hABCDEF;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [23:0] c;
    logic [31:0] t;
  } ent_t;

  logic clk, reset, start, pix_ready_i;
  logic [NQ-1:0] q_en_i, q_pop_o;
  logic [NQ*24-1:0] q_colour_i;
  logic [NQ*32-1:0] q_xpixel_i, q_ypixel_i;
  logic [31:0] xpixel_check, ypixel_check;
  logic [23:0] pix_colour_o;
  logic pix_valid_o, pix_sof_o, pix_eol_o, busy, frame_done, lost_err;

  ent_t qs[NQ][$];
  int exp_q[NP];
  logic [23:0] exp_col[NP];
  int unsigned cyc;
  int npass, ntot;

  pixel_reorder_combinator #(
    .DATA_WIDTH(32), .RBG_SIZE(24), .NUM_QUEUES(NQ), .X_SIZE(XS), .Y_SIZE(YS),
    .TIMEOUT_CYCLES(TO), .FILL_COLOUR(FILL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .q_en_i(q_en_i), .q_colour_i(q_colour_i),
    .q_xpixel_i(q_xpixel_i), .q_ypixel_i(q_ypixel_i), .xpixel_check(xpixel_check),
    .ypixel_check(ypixel_check), .q_pop_o(q_pop_o), .pix_colour_o(pix_colour_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_sof_o(pix_sof_o),
    .pix_eol_o(pix_eol_o), .busy(busy), .frame_done(frame_done), .lost_err(lost_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic init_frame();
    for (int i = 0; i < NQ; i++) qs[i].delete();
    for (int p = 0; p < NP; p++) begin
      exp_q[p] = -1;
      exp_col[p] = FILL;
    end
  endtask

  // A result for raster position p lands in queue q, visible dly cycles from now.
  // When two queues carry the same coordinate the lower index is the one that must be emitted.
  task automatic add(input int q, input int p, input int dly);
    ent_t e;
    e.x = 32'(p % XS);
    e.y = 32'(p / XS);
    e.c = 24'($urandom);
    e.t = 32'(cyc) + 32'(dly);
    qs[q].push_back(e);
    if (exp_q[p] < 0 || q < exp_q[p]) begin
      exp_q[p] = q;
      exp_col[p] = e.c;
    end
  endtask

  // Heads not yet visible still present their coordinates, so q_en_i gating is exercised.
  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      if (qs[i].size() > 0) begin
        q_en_i[i] = qs[i][0].t <= 32'(cyc);
        q_colour_i[i*24 +: 24] = qs[i][0].c;
        q_xpixel_i[i*32 +: 32] = qs[i][0].x;
        q_ypixel_i[i*32 +: 32] = qs[i][0].y;
      end else begin
        q_en_i[i] = 1'b0;
        q_colour_i[i*24 +: 24] = '0;
        q_xpixel_i[i*32 +: 32] = '0;
        q_ypixel_i[i*32 +: 32] = '0;
      end
    end
  endtask

  task automatic run_frame(input int rmode, input int fill_p, input int abort_p);
    int idx, srch, ic, b;
    bit done, pstall;
    logic [23:0] pcol;
    idx = 0; srch = 0; done = 0; pstall = 0; pcol = '0; b = 0;
    @(negedge clk); cyc++; drive(); start = 1'b1; pix_ready_i = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && b < 400) begin
      cyc++;
      b++;
      drive();
      pix_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom % 2) : (cyc % 4 == 0);
      start = rmode == 1 ? ($urandom % 8 == 0) : 1'b0;
      #1;
      ic = idx < NP ? idx : NP - 1;
      chk("xcheck", xpixel_check, 64'(ic % XS));
      chk("ycheck", ypixel_check, 64'(ic / XS));
      if (q_pop_o != '0) begin
        chk("pop", q_pop_o, exp_q[ic] >= 0 ? 64'(1 << exp_q[ic]) : 64'(0));
        chk("pop_during_valid", pix_valid_o, 0);
        for (int k = 0; k < NQ; k++) if (q_pop_o[k] && qs[k].size() > 0) void'(qs[k].pop_front());
      end
      if (pix_valid_o) begin
        chk("colour", pix_colour_o, exp_col[ic]);
        chk("sof", pix_sof_o, 64'(ic == 0));
        chk("eol", pix_eol_o, 64'(ic % XS == XS - 1));
        if (pstall) chk("stall_hold", pix_colour_o, pcol);
        if (ic == fill_p && !pstall) chk("timeout_cycles", 64'(srch), TO);
        chk("frame_done", frame_done, 64'(pix_ready_i && ic == NP - 1));
        if (ic == abort_p) begin
          reset = 1'b0;
          #1;
          chk("rst_valid", pix_valid_o, 0);
          chk("rst_colour", pix_colour_o, 0);
          chk("rst_flags", {pix_sof_o, pix_eol_o, busy, frame_done, lost_err}, 0);
          chk("rst_pop", q_pop_o, 0);
          chk("rst_coords", {xpixel_check, ypixel_check}, 0);
          done = 1;
        end else if (pix_ready_i) begin
          idx++;
          srch = 0;
          pstall = 0;
          done = idx == NP;
        end else begin
          pstall = 1;
          pcol = pix_colour_o;
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
        if (busy) srch++;
      end
      if (!done) @(negedge clk);
    end
    chk("frame_complete", 64'(done), 1);
    start = 1'b0;
    if (abort_p < 0) begin
      @(negedge clk); cyc++; #1;
      chk("end_busy", busy, 0);
      chk("end_valid", pix_valid_o, 0);
      chk("end_done_pulse", frame_done, 0);
      chk("end_lost_err", lost_err, 64'(fill_p >= 0));
      chk("end_coords", {xpixel_check, ypixel_check}, {32'(XS - 1), 32'(YS - 1)});
    end
  endtask

  initial begin
    npass = 0; ntot = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; pix_ready_i = 1'b0;
    init_frame();
    drive();
    @(negedge clk); #1;
    chk("reset_valid", pix_valid_o, 0);
    chk("reset_flags", {pix_sof_o, pix_eol_o, busy, frame_done, lost_err}, 0);
    chk("reset_pop", q_pop_o, 0);
    chk("reset_coords", {xpixel_check, ypixel_check}, 0);
    @(negedge clk); reset = 1'b1;

    // results dealt round-robin in raster order, downstream always ready
    init_frame();
    for (int p = 0; p < NP; p++) add(p % NQ, p, 0);
    run_frame(0, -1, -1);

    // (1,0) visible in queue 2 well before (0,0) turns up in queue 0
    init_frame();
    add(0, 0, 5);
    add(2, 1, 0);
    for (int p = 2; p < NP; p++) add(int'($urandom_range(0, NQ - 1)), p, 0);
    run_frame(0, -1, -1);

    // random queue placement with random backpressure and ignored start pulses
    init_frame();
    for (int p = 0; p < NP; p++) add(int'($urandom_range(0, NQ - 1)), p, int'($urandom_range(0, 3)));
    run_frame(1, -1, -1);

    // (2,1) never produced: fill pixel after the timeout
    init_frame();
    for (int p = 0; p < NP; p++) if (p != 6) add(int'($urandom_range(0, NQ - 1)), p, 0);
    run_frame(0, 6, -1);

    // duplicate (0,0) in queues 1 and 3, ready low three cycles in four
    init_frame();
    add(3, 0, 0);
    add(1, 0, 0);
    for (int p = 1; p < NP; p++) add(int'($urandom_range(0, 2)), p, 0);
    run_frame(2, -1, -1);

    // reset while pixel 3 is being offered, then a clean frame
    init_frame();
    for (int p = 0; p < NP; p++) add(p % NQ, p, 0);
    run_frame(1, -1, 3);
    @(negedge clk); reset = 1'b1;
    init_frame();
    for (int p = 0; p < NP; p++) add(int'($urandom_range(0, NQ - 1)), p, 0);
    run_frame(0, -1, -1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
